// File: rtl/arc4_pkg.sv
// Shared types, constants and the seven-segment decoder for the ARC4 key cracker.
package arc4_pkg;

    typedef enum logic [2:0] {
        INIT,
        KSA,
        PRGA,
        CHECK,
        NEXT,
        FOUND,
        EXHAUSTED
    } state_t;

    localparam logic [7:0]  ASCII_MIN = 8'h20;
    localparam logic [7:0]  ASCII_MAX = 8'h7E;
    localparam logic [23:0] KEY_MAX   = 24'hFFFFFF;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    // Active-low segments, bit order gfedcba
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/crack.sv
// Cracking engine: key counter, S and plaintext memories, and the ARC4 search FSM.
module crack
    import arc4_pkg::*;
#(
    parameter int KEY_BITS  = 24,
    parameter int MEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    output logic [7:0]          ct_addr,
    input  logic [7:0]          ct_rddata,
    output logic [KEY_BITS-1:0] key,
    output logic                key_valid,
    output logic                exhausted
);

    localparam int NKB = KEY_BITS / 8;

    state_t              r_state;
    logic [KEY_BITS-1:0] r_key;
    logic                r_found;
    logic                r_exh;
    logic [7:0]          r_ct_addr;
    logic [7:0]          r_i;
    logic [7:0]          r_j;
    logic [7:0]          r_k;
    logic [1:0]          r_kidx;
    logic [7:0]          r_s  [MEM_DEPTH];
    logic [7:0]          r_pt [MEM_DEPTH];

    logic [7:0] w_kb;
    logic [7:0] w_ksa_si, w_ksa_j, w_ksa_sj;
    logic [7:0] w_i1, w_pr_si, w_pr_j, w_pr_sj, w_t, w_pad;
    logic [7:0] w_chk;

    always_comb begin
        w_kb = 8'h00;
        for (int b = 0; b < NKB; b++) begin
            if (r_kidx == 2'(b)) w_kb = r_key[KEY_BITS-1-8*b -: 8];
        end
        w_ksa_si = r_s[r_i];
        w_ksa_j  = r_j + w_ksa_si + w_kb;
        w_ksa_sj = r_s[w_ksa_j];
        w_i1     = r_i + 8'd1;
        w_pr_si  = r_s[w_i1];
        w_pr_j   = r_j + w_pr_si;
        w_pr_sj  = r_s[w_pr_j];
        w_t      = w_pr_si + w_pr_sj;
        // The pad is read from S after the swap, which lands in the same edge
        if (w_t == w_i1)        w_pad = w_pr_sj;
        else if (w_t == w_pr_j) w_pad = w_pr_si;
        else                    w_pad = r_s[w_t];
        w_chk = r_pt[r_k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_key     <= '0;
            r_found   <= 1'b0;
            r_exh     <= 1'b0;
            r_ct_addr <= 8'd0;
        end else begin
            case (r_state)
                INIT: begin
                    for (int n = 0; n < MEM_DEPTH; n++) r_s[n] <= 8'(n);
                    r_i     <= 8'd0;
                    r_j     <= 8'd0;
                    r_kidx  <= 2'd0;
                    r_state <= KSA;
                end
                KSA: begin
                    r_s[r_i]    <= w_ksa_sj;
                    r_s[w_ksa_j] <= w_ksa_si;
                    r_j    <= w_ksa_j;
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == 2'(NKB-1)) ? 2'd0 : r_kidx + 2'd1;
                    // ct[0] has been on the read port since the key started; start fetching ct[1]
                    if (r_i == 8'(MEM_DEPTH-2)) begin
                        r_pt[0]   <= ct_rddata;
                        r_ct_addr <= 8'd1;
                    end
                    if (r_i == 8'(MEM_DEPTH-1)) begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                        r_k <= 8'd1;
                        if (r_pt[0] == 8'd0) begin
                            r_found <= 1'b1;
                            r_state <= FOUND;
                        end else begin
                            r_state <= PRGA;
                        end
                    end
                end
                PRGA: begin
                    r_s[w_i1]   <= w_pr_sj;
                    r_s[w_pr_j] <= w_pr_si;
                    r_i       <= w_i1;
                    r_j       <= w_pr_j;
                    r_pt[r_k] <= w_pad ^ ct_rddata;
                    r_ct_addr <= r_k + 8'd1;
                    r_state   <= CHECK;
                end
                CHECK: begin
                    if (w_chk < ASCII_MIN || w_chk > ASCII_MAX) begin
                        r_state <= NEXT;
                    end else if (r_k == r_pt[0]) begin
                        r_found <= 1'b1;
                        r_state <= FOUND;
                    end else begin
                        r_k     <= r_k + 8'd1;
                        r_state <= PRGA;
                    end
                end
                NEXT: begin
                    r_ct_addr <= 8'd0;
                    if (r_key == KEY_MAX) begin
                        r_exh   <= 1'b1;
                        r_state <= EXHAUSTED;
                    end else begin
                        r_key   <= r_key + 1'b1;
                        r_state <= INIT;
                    end
                end
                FOUND, EXHAUSTED: r_state <= r_state;
                default:          r_state <= INIT;
            endcase
        end
    end

    assign ct_addr   = r_ct_addr;
    assign key       = r_key;
    assign key_valid = r_found;
    assign exhausted = r_exh;

endmodule

// File: rtl/ct_rom.sv
// Ciphertext memory: 256x8 single-port, synchronous read with one cycle of latency.
module ct_rom #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       i_clk,
    input  logic [7:0] i_addr,
    input  logic       i_wren,
    input  logic [7:0] i_wrdata,
    output logic [7:0] o_rddata
);

    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_rddata;

    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            r_mem[i_addr] <= i_wrdata;
        end
        r_rddata <= r_mem[i_addr];
    end

    assign o_rddata = r_rddata;

endmodule

// File: rtl/arc4_crack_top.sv
// Board top: ciphertext memory, one cracking engine and the registered key display.
module arc4_crack_top
    import arc4_pkg::*;
#(
    parameter int KEY_BITS  = 24,
    parameter int MEM_DEPTH = 256
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic                w_rst;
    logic [7:0]          w_ct_addr;
    logic [7:0]          w_ct_rddata;
    logic [KEY_BITS-1:0] w_key;
    logic                w_key_valid;
    logic                w_exhausted;
    logic                w_unused;

    assign w_rst    = ~KEY[3];
    assign w_unused = ^{SW, KEY[2:0]};

    ct_rom #(.MEM_DEPTH(MEM_DEPTH)) ct (
        .i_clk    (CLOCK_50),
        .i_addr   (w_ct_addr),
        .i_wren   (1'b0),
        .i_wrdata (8'h00),
        .o_rddata (w_ct_rddata)
    );

    crack #(.KEY_BITS(KEY_BITS), .MEM_DEPTH(MEM_DEPTH)) u_crack (
        .clk       (CLOCK_50),
        .rst       (w_rst),
        .ct_addr   (w_ct_addr),
        .ct_rddata (w_ct_rddata),
        .key       (w_key),
        .key_valid (w_key_valid),
        .exhausted (w_exhausted)
    );

    always_ff @(posedge CLOCK_50) begin
        if (w_rst) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX4 <= SEG_BLANK;
            HEX5 <= SEG_BLANK;
            LEDR <= '0;
        end else begin
            LEDR <= {8'b0, w_exhausted, w_key_valid};
            if (w_key_valid) begin
                HEX5 <= hex_to_seg(w_key[KEY_BITS-1  -: 4]);
                HEX4 <= hex_to_seg(w_key[KEY_BITS-5  -: 4]);
                HEX3 <= hex_to_seg(w_key[KEY_BITS-9  -: 4]);
                HEX2 <= hex_to_seg(w_key[KEY_BITS-13 -: 4]);
                HEX1 <= hex_to_seg(w_key[KEY_BITS-17 -: 4]);
                HEX0 <= hex_to_seg(w_key[KEY_BITS-21 -: 4]);
            end else if (w_exhausted) begin
                HEX0 <= SEG_DASH;
                HEX1 <= SEG_DASH;
                HEX2 <= SEG_DASH;
                HEX3 <= SEG_DASH;
                HEX4 <= SEG_DASH;
                HEX5 <= SEG_DASH;
            end else begin
                HEX0 <= SEG_BLANK;
                HEX1 <= SEG_BLANK;
                HEX2 <= SEG_BLANK;
                HEX3 <= SEG_BLANK;
                HEX4 <= SEG_BLANK;
                HEX5 <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_arc4_crack_top.sv
// Bench for arc4_crack_top: table of search scenarios checked against an ARC4 reference model.
module tb_arc4_crack_top;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = '0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    arc4_crack_top dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [7:0] m_ct [256];
    logic [7:0] m_ks [256];

    typedef struct {
        logic [23:0] key;
        logic [23:0] start;
        int          len;
        int          kind;      // 0: printable text, 1: no valid key, 2: single byte tuned
        bit          exp_found;
        logic [23:0] exp_key;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Plain ARC4: fills m_ks[1..len] with the keystream of key k
    function automatic void keystream(input logic [23:0] k, input int len);
        logic [7:0] s [256];
        logic [7:0] i, j, tmp, kb;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            kb   = 8'(k >> (16 - 8 * (n % 3)));
            j    = j + s[n] + kb;
            tmp  = s[n];
            s[n] = s[j];
            s[j] = tmp;
        end
        i = 8'd0;
        j = 8'd0;
        for (int n = 1; n <= len; n++) begin
            i       = i + 8'd1;
            j       = j + s[i];
            tmp     = s[i];
            s[i]    = s[j];
            s[j]    = tmp;
            m_ks[n] = s[8'(s[i] + s[j])];
        end
    endfunction

    function automatic bit key_ok(input logic [23:0] k);
        int len;
        len = int'(m_ct[0]);
        keystream(k, len);
        for (int n = 1; n <= len; n++) begin
            if (!is_print(m_ct[n] ^ m_ks[n])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void find_key(input logic [23:0] start, output bit found, output logic [23:0] k);
        found = 1'b0;
        k     = 24'd0;
        for (int unsigned c = 32'(start); c <= 32'hFFFFFF; c++) begin
            if (key_ok(24'(c))) begin
                found = 1'b1;
                k     = 24'(c);
                return;
            end
        end
    endfunction

    task automatic prepare(inout vec_t v);
        logic [7:0] ks_t, ctb;
        bit         good;
        for (int n = 0; n < 256; n++) m_ct[n] = 8'($urandom);
        m_ct[0] = 8'(v.len);
        if (v.kind == 0) begin
            keystream(v.key, v.len);
            for (int n = 1; n <= v.len; n++)
                m_ct[n] = 8'($urandom_range(32, 126)) ^ m_ks[n];
        end else if (v.kind == 2) begin
            keystream(v.key, 1);
            ks_t = m_ks[1];
            ctb  = 8'h20 ^ ks_t;
            for (int cc = 32; cc <= 126; cc++) begin
                ctb  = 8'(cc) ^ ks_t;
                good = 1'b1;
                for (int unsigned c = 32'(v.start); c < 32'(v.key); c++) begin
                    keystream(24'(c), 1);
                    if (is_print(ctb ^ m_ks[1])) good = 1'b0;
                end
                if (good) break;
            end
            m_ct[1] = ctb;
        end else begin
            for (int tries = 0; tries < 32; tries++) begin
                for (int n = 1; n <= v.len; n++) m_ct[n] = 8'($urandom);
                find_key(v.start, good, ks_t);
                if (!good) break;
            end
        end
        find_key(v.start, v.exp_found, v.exp_key);
    endtask

    task automatic start_search(input logic [23:0] start);
        @(negedge CLOCK_50);
        KEY[3] = 1'b0;
        for (int n = 0; n < 256; n++) dut.ct.r_mem[n] = m_ct[n];
        repeat (2) @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        dut.u_crack.r_key = start;
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (LEDR[1:0] == 2'b00 && cyc < budget) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check("done_within_budget", {31'b0, LEDR[1:0] != 2'b00}, 32'd1);
    endtask

    task automatic check_display(input string tag, input bit found, input logic [23:0] k);
        logic [6:0] act [6];
        logic [6:0] exp;
        act = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
        check({tag, "_ledr"}, 32'(LEDR), found ? 32'd1 : 32'd2);
        for (int d = 0; d < 6; d++) begin
            exp = found ? seg_tab[4'(k >> (4 * d))] : 7'b0111111;
            check($sformatf("%s_hex%0d", tag, d), 32'(act[d]), 32'(exp));
        end
    endtask

    task automatic check_blank(input string tag);
        logic [6:0] act [6];
        act = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
        check({tag, "_ledr"}, 32'(LEDR), 32'd0);
        for (int d = 0; d < 6; d++)
            check($sformatf("%s_hex%0d", tag, d), 32'(act[d]), 32'h7F);
    endtask

    task automatic check_pt(input string tag, input vec_t v);
        if (v.exp_found) begin
            keystream(v.exp_key, v.len);
            check({tag, "_pt0"}, 32'(dut.u_crack.r_pt[0]), 32'(v.len));
            for (int n = 1; n <= v.len; n++)
                check($sformatf("%s_pt%0d", tag, n), 32'(dut.u_crack.r_pt[n]), 32'(m_ct[n] ^ m_ks[n]));
        end
    endtask

    function automatic int budget_for(input vec_t v);
        int keys;
        keys = v.exp_found ? int'(v.exp_key - v.start) + 1 : int'(24'hFFFFFF - v.start) + 1;
        return keys * (270 + 2 * v.len) + 200;
    endfunction

    initial begin
        vec_t v;
        int   cyc;

        // Reset state
        KEY = 4'b0111;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_blank("reset");
        KEY[3] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("reset_key0", 32'(dut.u_crack.r_key), 32'd0);

        vecs[0] = '{key: 24'h000018, start: 24'h000000, len: 13, kind: 0, exp_found: 1'b0, exp_key: 24'h0};
        vecs[1] = '{key: 24'h000000, start: 24'h000000, len: 8,  kind: 0, exp_found: 1'b0, exp_key: 24'h0};
        vecs[2] = '{key: 24'h000000, start: 24'h000000, len: 0,  kind: 0, exp_found: 1'b0, exp_key: 24'h0};
        vecs[3] = '{key: 24'hABCDEF, start: 24'hABCDE0, len: 1,  kind: 2, exp_found: 1'b0, exp_key: 24'h0};
        vecs[4] = '{key: 24'h000000, start: 24'hFFFFF0, len: 4,  kind: 1, exp_found: 1'b0, exp_key: 24'h0};
        for (int r = 5; r < 7; r++) begin
            vecs[r].key       = 24'($urandom_range(8, 32'hFFFFFF));
            vecs[r].start     = vecs[r].key - 24'($urandom_range(0, 6));
            vecs[r].len       = int'($urandom_range(3, 6));
            vecs[r].kind      = 0;
            vecs[r].exp_found = 1'b0;
            vecs[r].exp_key   = 24'h0;
        end

        for (int t = 0; t < 7; t++) begin
            v = vecs[t];
            prepare(v);
            start_search(v.start);
            repeat (4) @(negedge CLOCK_50);
            if (v.len > 0) check_blank($sformatf("v%0d_searching", t));
            wait_done(budget_for(v));
            @(negedge CLOCK_50);
            check_display($sformatf("v%0d", t), v.exp_found, v.exp_key);
            check_pt($sformatf("v%0d", t), v);
        end

        // Reset in the middle of key 5's KSA, then an uninterrupted-equivalent rerun
        v = '{key: 24'h000018, start: 24'h000000, len: 10, kind: 0, exp_found: 1'b0, exp_key: 24'h0};
        prepare(v);
        start_search(24'h000000);
        cyc = 0;
        while (dut.u_crack.r_key != 24'd5 && cyc < 5000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check("mid_reached_key5", 32'(dut.u_crack.r_key), 32'd5);
        repeat (20) @(negedge CLOCK_50);
        KEY[3] = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check_blank("mid_reset");
        check("mid_reset_key0", 32'(dut.u_crack.r_key), 32'd0);
        KEY[3] = 1'b1;
        wait_done(budget_for(v));
        @(negedge CLOCK_50);
        check_display("mid", v.exp_found, v.exp_key);
        check_pt("mid", v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
